int_controller: RTL and testbench

- Prioritised maskable-interrupt controller for the Z80 /INT line, clocked by the CPU clock.
- Merges three request sources into one /INT pulse of programmable length:
  - FRAME: frame interrupt from the video counter timing point.
  - LINE: raster-line interrupt.
  - EXT: expansion-bus interrupt.
- Detects the CPU acknowledge cycle and supplies an optional IM2 vector on the data bus.
- Replaces the single fixed-frame /INT generator beside the CPU clock/contention logic.

---
 rtl/int_controller_pkg.sv | 30 +++
 rtl/int_controller_prio.sv | 22 ++
 rtl/int_controller.sv | 137 +++++++++++++
 tb/tb_int_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_controller_pkg.sv
// Shared types and defaults for the Z80 /INT controller.
package int_controller_pkg;

  localparam int         INT_LEN_DEF  = 32;
  localparam logic [7:0] CFG_PORT_DEF = 8'hE7;
  localparam logic [7:0] VEC_BASE_DEF = 8'hF8;

  typedef enum logic [1:0] {
    INT_SRC_FRAME = 2'd0,
    INT_SRC_LINE  = 2'd1,
    INT_SRC_EXT   = 2'd2
  } int_src_t;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    ACK,
    GAP
  } int_state_t;

  function automatic logic [2:0] src_onehot(int_src_t s);
    return 3'b001 << s;
  endfunction

  // IM2 vector: source index in bits [2:1], bit 0 forced high.
  function automatic logic [7:0] im2_vec(logic [7:0] base, int_src_t s);
    return base | {5'b00000, s, 1'b1};
  endfunction

endpackage

// File: rtl/int_controller_prio.sv
// Fixed-priority encoder over active requests: FRAME > LINE > EXT.
module int_prio
  import int_controller_pkg::*;
(
  input  logic [2:0] act_i,
  output logic       vld_o,
  output int_src_t   src_o
);

  always_comb begin
    vld_o = |act_i;
    src_o = INT_SRC_FRAME;
    if (act_i[0]) begin
      src_o = INT_SRC_FRAME;
    end else if (act_i[1]) begin
      src_o = INT_SRC_LINE;
    end else if (act_i[2]) begin
      src_o = INT_SRC_EXT;
    end
  end

endmodule

// File: rtl/int_controller.sv
// Prioritised maskable /INT generator with acknowledge detection, optional IM2 vector
// and a config/status I/O port.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int         INT_LEN  = INT_LEN_DEF,
  parameter logic [7:0] CFG_PORT = CFG_PORT_DEF,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       req_frame,
  input  logic       req_line,
  input  logic       req_ext,
  input  logic       m1,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] a,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_out_oe,
  output logic       n_int
);

  localparam logic [5:0] LAST_CNT = 6'(INT_LEN - 1);

  int_state_t state_q, state_d;
  int_src_t   src_q, src_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] en_q, en_d;
  logic       vec_mode_q, vec_mode_d;
  logic       cfg_wr_q;
  logic       n_int_q, n_int_d;

  logic       ack_cyc, cfg_wr_hit, cfg_wr_stb, cfg_rd_hit, timeout;
  logic [2:0] pend_clr, w1c_clr, req_vec;
  logic       arb_vld;
  int_src_t   arb_src;
  logic       unused_d7;

  assign unused_d7  = d_in[7];
  assign ack_cyc    = m1 && iorq;
  assign cfg_wr_hit = iorq && wr && !m1 && (a == CFG_PORT);
  assign cfg_wr_stb = cfg_wr_hit && !cfg_wr_q;
  assign cfg_rd_hit = iorq && rd && !m1 && (a == CFG_PORT);
  assign timeout    = (cnt_q == LAST_CNT);
  assign req_vec    = {req_ext, req_line, req_frame};
  assign w1c_clr    = cfg_wr_stb ? d_in[6:4] : 3'b000;

  int_prio u_prio (
    .act_i (pend_q & en_q),
    .vld_o (arb_vld),
    .src_o (arb_src)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cnt_d    = 6'd0;
    pend_clr = 3'b000;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = ASSERT;
          src_d   = arb_src;
        end
      end
      ASSERT: begin
        cnt_d = cnt_q + 6'd1;
        if (ack_cyc) begin
          state_d  = ACK;
          pend_clr = src_onehot(src_q);
        end else if (timeout) begin
          state_d = GAP;
          // A missed frame interrupt is lost; LINE/EXT retry after the gap.
          if (src_q == INT_SRC_FRAME) pend_clr = 3'b001;
        end
      end
      ACK: begin
        if (!ack_cyc) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requests override any same-cycle clear.
  always_comb begin
    pend_d     = (pend_q & ~pend_clr & ~w1c_clr) | req_vec;
    en_d       = cfg_wr_stb ? d_in[2:0] : en_q;
    vec_mode_d = cfg_wr_stb ? d_in[3]   : vec_mode_q;
    n_int_d    = (state_d != ASSERT);
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= INT_SRC_FRAME;
      cnt_q      <= 6'd0;
      pend_q     <= 3'b000;
      en_q       <= 3'b001;
      vec_mode_q <= 1'b0;
      cfg_wr_q   <= 1'b0;
      n_int_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      vec_mode_q <= vec_mode_d;
      cfg_wr_q   <= cfg_wr_hit;
      n_int_q    <= n_int_d;
    end
  end

  always_comb begin
    d_out    = 8'hFF;
    d_out_oe = 1'b0;
    if ((state_q == ACK) && ack_cyc && vec_mode_q) begin
      d_out_oe = 1'b1;
      d_out    = im2_vec(VEC_BASE, src_q);
    end else if (cfg_rd_hit) begin
      d_out_oe = 1'b1;
      d_out    = {1'b0, pend_q, vec_mode_q, en_q};
    end
  end

  assign n_int = n_int_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus randomized interrupt transactions.
module tb_int_controller;

  localparam int         INT_LEN  = 32;
  localparam logic [7:0] CFG_PORT = 8'hE7;
  localparam logic [7:0] VEC_BASE = 8'hF8;

  logic       clkcpu = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_frame = 1'b0, req_line = 1'b0, req_ext = 1'b0;
  logic       m1 = 1'b0, iorq = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0] a = 8'h00, d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_out_oe;
  logic       n_int;

  int checks = 0;
  int errors = 0;

  int_controller #(.INT_LEN(INT_LEN), .CFG_PORT(CFG_PORT), .VEC_BASE(VEC_BASE)) dut (
    .clkcpu(clkcpu), .rst_n(rst_n), .req_frame(req_frame), .req_line(req_line),
    .req_ext(req_ext), .m1(m1), .iorq(iorq), .rd(rd), .wr(wr), .a(a), .d_in(d_in),
    .d_out(d_out), .d_out_oe(d_out_oe), .n_int(n_int)
  );

  always #5 clkcpu = ~clkcpu;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary, required normal finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkcpu);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] v);
    a = CFG_PORT; d_in = v; iorq = 1'b1; wr = 1'b1;
    tick();
    iorq = 1'b0; wr = 1'b0; d_in = 8'h00;
  endtask

  task automatic status_read(output logic [7:0] v, output logic oe);
    a = CFG_PORT; iorq = 1'b1; rd = 1'b1;
    #1;
    v = d_out; oe = d_out_oe;
    iorq = 1'b0; rd = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] vec_of(int src);
    return VEC_BASE | 8'(src * 2) | 8'h01;
  endfunction

  task automatic test_reset();
    logic [7:0] v; logic oe;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL reset_n_int: got %b want 1", n_int); end
    checks++; if (d_out_oe !== 1'b0 || d_out !== 8'hFF) begin
      errors++; $display("FAIL reset_bus: got oe=%b d=%h want oe=0 d=ff", d_out_oe, d_out); end
    rst_n = 1'b1;
    tick();
    status_read(v, oe);
    checks++; if (oe !== 1'b1 || v !== 8'h01) begin
      errors++; $display("FAIL reset_status: got oe=%b d=%h want oe=1 d=01", oe, v); end
  endtask

  task automatic test_frame_timeout();
    logic [7:0] v; logic oe; int n, z;
    req_frame = 1'b1; tick(); req_frame = 1'b0;
    checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL frame_early: got %b want 1", n_int); end
    tick();
    checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL frame_assert: got %b want 0", n_int); end
    status_read(v, oe);
    checks++; if (v !== 8'h11) begin errors++; $display("FAIL frame_pending: got %h want 11", v); end
    n = 0;
    while (n_int === 1'b0 && n < 100) begin n++; tick(); end
    checks++; if (n != INT_LEN) begin errors++; $display("FAIL frame_len: got %0d want %0d", n, INT_LEN); end
    status_read(v, oe);
    checks++; if (oe !== 1'b1 || v !== 8'h01) begin
      errors++; $display("FAIL frame_dropped: got oe=%b d=%h want oe=1 d=01", oe, v); end
    z = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (n_int === 1'b0) z++; end
    checks++; if (z != 0) begin errors++; $display("FAIL frame_no_retry: got %0d low cycles want 0", z); end
  endtask

  task automatic test_vector_ack();
    logic [7:0] v; logic oe;
    cfg_write(8'h0F);
    status_read(v, oe);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL cfg_readback: got %h want 0f", v); end
    req_ext = 1'b1; tick(); req_ext = 1'b0;
    tick();
    checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL ext_assert: got %b want 0", n_int); end
    repeat (4) tick();
    m1 = 1'b1; iorq = 1'b1;
    tick();
    checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL ext_release: got %b want 1", n_int); end
    checks++; if (d_out_oe !== 1'b1 || d_out !== 8'hFD) begin
      errors++; $display("FAIL ext_vector: got oe=%b d=%h want oe=1 d=fd", d_out_oe, d_out); end
    m1 = 1'b0; iorq = 1'b0;
    #1;
    checks++; if (d_out_oe !== 1'b0) begin errors++; $display("FAIL ext_vec_off: got %b want 0", d_out_oe); end
    tick(); tick();
    status_read(v, oe);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL ext_cleared: got %h want 0f", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v; logic oe; int hi;
    req_frame = 1'b1; req_line = 1'b1; tick(); req_frame = 1'b0; req_line = 1'b0;
    tick();
    checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL b2b_first: got %b want 0", n_int); end
    m1 = 1'b1; iorq = 1'b1; tick();
    checks++; if (d_out_oe !== 1'b1 || d_out !== 8'hF9) begin
      errors++; $display("FAIL b2b_vec1: got oe=%b d=%h want oe=1 d=f9", d_out_oe, d_out); end
    m1 = 1'b0; iorq = 1'b0;
    tick();
    hi = 0;
    while (n_int === 1'b1 && hi < 20) begin hi++; tick(); end
    // High spans the GAP cycle plus the IDLE arbitration cycle.
    checks++; if (hi != 2) begin errors++; $display("FAIL b2b_gap: got %0d high cycles want 2", hi); end
    m1 = 1'b1; iorq = 1'b1; tick();
    checks++; if (d_out_oe !== 1'b1 || d_out !== 8'hFB) begin
      errors++; $display("FAIL b2b_vec2: got oe=%b d=%h want oe=1 d=fb", d_out_oe, d_out); end
    m1 = 1'b0; iorq = 1'b0;
    tick(); tick(); tick();
    status_read(v, oe);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL b2b_status: got %h want 0f", v); end
  endtask

  task automatic test_line_retry();
    logic [7:0] v; logic oe; int n, hi, z;
    req_line = 1'b1; tick(); req_line = 1'b0;
    tick();
    n = 0;
    while (n_int === 1'b0 && n < 100) begin n++; tick(); end
    checks++; if (n != INT_LEN) begin errors++; $display("FAIL line_len: got %0d want %0d", n, INT_LEN); end
    hi = 0;
    while (n_int === 1'b1 && hi < 20) begin hi++; tick(); end
    checks++; if (hi != 2) begin errors++; $display("FAIL line_gap: got %0d high cycles want 2", hi); end
    checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL line_retry: got %b want 0", n_int); end
    n = 1;
    cfg_write(8'h2F);
    n++;
    status_read(v, oe);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL line_w1c: got %h want 0f", v); end
    while (n_int === 1'b0 && n < 100) begin n++; tick(); end
    checks++; if (n != INT_LEN + 1) begin
      errors++; $display("FAIL line_len2: got %0d want %0d", n - 1, INT_LEN); end
    z = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (n_int === 1'b0) z++; end
    checks++; if (z != 0) begin errors++; $display("FAIL line_quiet: got %0d low cycles want 0", z); end
  endtask

  task automatic test_set_wins();
    logic [7:0] v; logic oe; int n;
    req_frame = 1'b1;
    cfg_write(8'h1F);
    req_frame = 1'b0;
    status_read(v, oe);
    checks++; if (v !== 8'h1F) begin errors++; $display("FAIL set_wins: got %h want 1f", v); end
    n = 0;
    while (n_int !== 1'b0 && n < 5) begin n++; tick(); end
    n = 0;
    while (n_int === 1'b0 && n < 100) begin n++; tick(); end
    checks++; if (n != INT_LEN) begin errors++; $display("FAIL set_wins_len: got %0d want %0d", n, INT_LEN); end
    tick(); tick();
  endtask

  task automatic test_reset_during_ack();
    logic [7:0] v; logic oe;
    req_frame = 1'b1; tick(); req_frame = 1'b0;
    tick();
    m1 = 1'b1; iorq = 1'b1; tick();
    checks++; if (d_out_oe !== 1'b1 || d_out !== 8'hF9) begin
      errors++; $display("FAIL rst_ack_vec: got oe=%b d=%h want oe=1 d=f9", d_out_oe, d_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (d_out_oe !== 1'b0 || n_int !== 1'b1 || d_out !== 8'hFF) begin
      errors++; $display("FAIL rst_async: got oe=%b n_int=%b d=%h want oe=0 n_int=1 d=ff", d_out_oe, n_int, d_out); end
    m1 = 1'b0; iorq = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    status_read(v, oe);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL rst_defaults: got %h want 01", v); end
  endtask

  task automatic test_random();
    logic [2:0] pend, en, r, act;
    logic vm, oe, ok;
    logic [7:0] v, exp_d;
    int src, k, h, n;
    for (int t = 0; t < 25; t++) begin
      en = 3'($urandom_range(0, 7));
      vm = 1'($urandom_range(0, 1));
      cfg_write({1'b0, 3'b111, vm, en});
      pend = 3'b000;
      r = 3'($urandom_range(1, 7));
      {req_ext, req_line, req_frame} = r;
      tick();
      {req_ext, req_line, req_frame} = 3'b000;
      pend = pend | r;
      ok = 1'b1;
      for (int i = 0; i < 6 && ok && (pend & en) != 3'b000; i++) begin
        act = pend & en;
        src = act[0] ? 0 : (act[1] ? 1 : 2);
        n = 0;
        while (n_int !== 1'b0 && n < 8) begin n++; tick(); end
        checks++;
        if (n_int !== 1'b0) begin
          errors++; ok = 1'b0;
          $display("FAIL rand_assert: t=%0d got n_int=%b want 0 within 8 cycles", t, n_int);
        end else if ($urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, INT_LEN - 1);
          repeat (k) tick();
          checks++; if (n_int !== 1'b0) begin
            errors++; $display("FAIL rand_hold: t=%0d k=%0d got %b want 0", t, k, n_int); end
          m1 = 1'b1; iorq = 1'b1;
          tick();
          checks++; if (n_int !== 1'b1) begin
            errors++; $display("FAIL rand_release: t=%0d got %b want 1", t, n_int); end
          h = $urandom_range(0, 2);
          repeat (h) tick();
          exp_d = vm ? vec_of(src) : 8'hFF;
          checks++; if (d_out_oe !== vm || d_out !== exp_d) begin
            errors++; $display("FAIL rand_vector: t=%0d got oe=%b d=%h want oe=%b d=%h", t, d_out_oe, d_out, vm, exp_d); end
          m1 = 1'b0; iorq = 1'b0;
          pend[src] = 1'b0;
        end else begin
          n = 0;
          while (n_int === 1'b0 && n < 100) begin n++; tick(); end
          checks++; if (n != INT_LEN) begin
            errors++; $display("FAIL rand_timeout: t=%0d got %0d want %0d", t, n, INT_LEN); end
          if (src == 0) pend[0] = 1'b0;
        end
      end
      if (ok) begin
        repeat (4) tick();
        checks++; if (n_int !== 1'b1) begin
          errors++; $display("FAIL rand_quiet: t=%0d got %b want 1", t, n_int); end
        status_read(v, oe);
        checks++; if (v !== {1'b0, pend, vm, en}) begin
          errors++; $display("FAIL rand_status: t=%0d got %h want %h", t, v, {1'b0, pend, vm, en}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_timeout();
    test_vector_ack();
    test_back_to_back();
    test_line_retry();
    test_set_wins();
    test_reset_during_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
